// File: rtl/branch_target_predictor.sv
// Direct-mapped branch target buffer with per-entry saturating direction counters.
// Combinational lookup for fetch, clocked update from execute, misprediction statistics.

module branch_target_predictor_entry #(
    parameter int ADDR_WIDTH   = 32,
    parameter int TAG_BITS     = 26,
    parameter int COUNTER_BITS = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    write,
    input  logic                    taken,
    input  logic [TAG_BITS-1:0]     write_tag,
    input  logic [ADDR_WIDTH-1:0]   write_target,
    output logic                    valid,
    output logic [TAG_BITS-1:0]     tag,
    output logic [ADDR_WIDTH-1:0]   target,
    output logic [COUNTER_BITS-1:0] ctr
);
    localparam logic [COUNTER_BITS-1:0] CTR_MAX  = '1;
    localparam logic [COUNTER_BITS-1:0] CTR_WEAK = COUNTER_BITS'(1) << (COUNTER_BITS - 1);

    logic hit;
    assign hit = valid && (tag == write_tag);

    // Only valid is reset; tag/target/ctr are don't-care while the entry is invalid.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            valid <= 1'b0;
        end else if (write) begin
            if (hit) begin
                if (taken) begin
                    if (ctr != CTR_MAX) ctr <= ctr + COUNTER_BITS'(1);
                    target <= write_target;
                end else if (ctr != '0) begin
                    ctr <= ctr - COUNTER_BITS'(1);
                end
            end else if (taken) begin
                valid  <= 1'b1;
                tag    <= write_tag;
                target <= write_target;
                ctr    <= CTR_WEAK;
            end
        end
    end
endmodule

module branch_target_predictor #(
    parameter int ADDR_WIDTH   = 32,
    parameter int INDEX_BITS   = 4,
    parameter int COUNTER_BITS = 2,
    parameter int TAG_BITS     = ADDR_WIDTH - INDEX_BITS - 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] lookup_pc,
    output logic                  predict_hit,
    output logic                  predict_taken,
    output logic [ADDR_WIDTH-1:0] predict_next_pc,
    input  logic                  update_valid,
    input  logic [ADDR_WIDTH-1:0] update_pc,
    input  logic                  update_taken,
    input  logic [ADDR_WIDTH-1:0] update_target,
    input  logic                  update_pred_taken,
    input  logic [ADDR_WIDTH-1:0] update_pred_target,
    input  logic                  flush,
    output logic                  mispredict,
    output logic [31:0]           branch_count,
    output logic [31:0]           mispredict_count
);
    localparam int ENTRIES = 1 << INDEX_BITS;

    logic [ENTRIES-1:0]                   ent_valid;
    logic [ENTRIES-1:0]                   ent_write;
    logic [ENTRIES-1:0][TAG_BITS-1:0]     ent_tag;
    logic [ENTRIES-1:0][ADDR_WIDTH-1:0]   ent_target;
    logic [ENTRIES-1:0][COUNTER_BITS-1:0] ent_ctr;

    logic [INDEX_BITS-1:0] lookup_idx, update_idx;
    logic [TAG_BITS-1:0]   lookup_tag, update_tag;
    logic                  miss_event;
    logic [31:0]           branch_next, mispredict_next;
    logic                  unused_pc_bits;

    assign lookup_idx     = lookup_pc[INDEX_BITS+1:2];
    assign lookup_tag     = lookup_pc[ADDR_WIDTH-1:INDEX_BITS+2];
    assign update_idx     = update_pc[INDEX_BITS+1:2];
    assign update_tag     = update_pc[ADDR_WIDTH-1:INDEX_BITS+2];
    assign unused_pc_bits = &{1'b0, update_pc[1:0]};

    for (genvar i = 0; i < ENTRIES; i++) begin : g_entry
        assign ent_write[i] = update_valid && (update_idx == INDEX_BITS'(i));

        branch_target_predictor_entry #(
            .ADDR_WIDTH  (ADDR_WIDTH),
            .TAG_BITS    (TAG_BITS),
            .COUNTER_BITS(COUNTER_BITS)
        ) u_entry (
            .clock       (clock),
            .reset       (reset),
            .flush       (flush),
            .write       (ent_write[i]),
            .taken       (update_taken),
            .write_tag   (update_tag),
            .write_target(update_target),
            .valid       (ent_valid[i]),
            .tag         (ent_tag[i]),
            .target      (ent_target[i]),
            .ctr         (ent_ctr[i])
        );
    end

    // Counter MSB set is exactly ctr >= 2^(COUNTER_BITS-1).
    assign predict_hit     = ent_valid[lookup_idx] && (ent_tag[lookup_idx] == lookup_tag);
    assign predict_taken   = predict_hit && ent_ctr[lookup_idx][COUNTER_BITS-1];
    assign predict_next_pc = predict_taken ? ent_target[lookup_idx]
                                           : lookup_pc + ADDR_WIDTH'(4);

    assign miss_event = update_valid &&
                        ((update_taken != update_pred_taken) ||
                         (update_taken && (update_target != update_pred_target)));

    always_comb begin
        branch_next     = branch_count;
        mispredict_next = mispredict_count;
        if (update_valid && (branch_count != '1)) branch_next = branch_count + 32'd1;
        if (miss_event && (mispredict_count != '1)) mispredict_next = mispredict_count + 32'd1;
    end

    // Statistics are re-registered every cycle, even when unchanged.
    always_ff @(posedge clock) begin
        if (reset) begin
            mispredict       <= 1'b0;
            branch_count     <= '0;
            mispredict_count <= '0;
        end else begin
            mispredict       <= miss_event;
            branch_count     <= branch_next;
            mispredict_count <= mispredict_next;
        end
    end
endmodule

// File: tb/tb_branch_target_predictor.sv
// Randomized + directed bench for branch_target_predictor against an array-based reference model.

module tb_branch_target_predictor;
    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] lookup_pc;
    logic        predict_hit, predict_taken;
    logic [31:0] predict_next_pc;
    logic        update_valid, update_taken, update_pred_taken, flush;
    logic [31:0] update_pc, update_target, update_pred_target;
    logic        mispredict;
    logic [31:0] branch_count, mispredict_count;

    branch_target_predictor dut (
        .clock             (clock),
        .reset             (reset),
        .lookup_pc         (lookup_pc),
        .predict_hit       (predict_hit),
        .predict_taken     (predict_taken),
        .predict_next_pc   (predict_next_pc),
        .update_valid      (update_valid),
        .update_pc         (update_pc),
        .update_taken      (update_taken),
        .update_target     (update_target),
        .update_pred_taken (update_pred_taken),
        .update_pred_target(update_pred_target),
        .flush             (flush),
        .mispredict        (mispredict),
        .branch_count      (branch_count),
        .mispredict_count  (mispredict_count)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Reference model: one slot per index, counter as a plain integer 0..3.
    bit          m_valid [16];
    bit [31:0]   m_tag   [16];
    bit [31:0]   m_target[16];
    int          m_ctr   [16];
    bit          m_mis;
    longint      m_bc, m_mc;
    localparam longint SAT = 64'h0000_0000_FFFF_FFFF;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic m_lookup(input bit [31:0] pc, output bit h, output bit t, output bit [31:0] nx);
        int idx = int'((pc / 4) % 16);
        h  = m_valid[idx] && (m_tag[idx] == pc / 64);
        t  = h && (m_ctr[idx] >= 2);
        nx = t ? m_target[idx] : pc + 32'd4;
    endtask

    task automatic m_apply(input bit rst, input bit uv, input bit [31:0] upc, input bit ut,
                           input bit [31:0] utgt, input bit upt, input bit [31:0] uptgt,
                           input bit fl);
        int idx = int'((upc / 4) % 16);
        bit m;
        bit h;
        if (rst) begin
            for (int i = 0; i < 16; i++) m_valid[i] = 0;
            m_mis = 0; m_bc = 0; m_mc = 0;
            return;
        end
        m = uv && ((ut != upt) || (ut && utgt != uptgt));
        m_mis = m;
        if (uv) m_bc = (m_bc == SAT) ? SAT : m_bc + 1;
        if (m)  m_mc = (m_mc == SAT) ? SAT : m_mc + 1;
        if (fl) begin
            for (int i = 0; i < 16; i++) m_valid[i] = 0;
        end else if (uv) begin
            h = m_valid[idx] && (m_tag[idx] == upc / 64);
            if (h && ut) begin
                m_ctr[idx] = (m_ctr[idx] + 1 > 3) ? 3 : m_ctr[idx] + 1;
                m_target[idx] = utgt;
            end else if (h) begin
                m_ctr[idx] = (m_ctr[idx] - 1 < 0) ? 0 : m_ctr[idx] - 1;
            end else if (ut) begin
                m_valid[idx] = 1; m_tag[idx] = upc / 64; m_target[idx] = utgt; m_ctr[idx] = 2;
            end
        end
    endtask

    // One cycle: drive at negedge, check lookup before the edge, check registered outputs after.
    task automatic step(input bit rst, input bit [31:0] lpc, input bit uv, input bit [31:0] upc,
                        input bit ut, input bit [31:0] utgt, input bit upt,
                        input bit [31:0] uptgt, input bit fl);
        bit h, t;
        bit [31:0] nx;
        reset = rst; lookup_pc = lpc; update_valid = uv; update_pc = upc; update_taken = ut;
        update_target = utgt; update_pred_taken = upt; update_pred_target = uptgt; flush = fl;
        #1;
        m_lookup(lpc, h, t, nx);
        chk("hit", 32'(predict_hit), 32'(h));
        chk("taken", 32'(predict_taken), 32'(t));
        chk("next_pc", predict_next_pc, nx);
        @(posedge clock);
        m_apply(rst, uv, upc, ut, utgt, upt, uptgt, fl);
        @(negedge clock);
        chk("mispredict", 32'(mispredict), 32'(m_mis));
        chk("branch_count", branch_count, m_bc[31:0]);
        chk("mispredict_count", mispredict_count, m_mc[31:0]);
    endtask

    task automatic look(input bit [31:0] pc);
        step(0, pc, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic upd(input bit [31:0] pc, input bit ut, input bit [31:0] tgt,
                       input bit upt, input bit [31:0] ptgt);
        step(0, pc, 1, pc, ut, tgt, upt, ptgt, 0);
    endtask

    function automatic bit [31:0] rand_pc();
        return ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) |
               ($urandom_range(0, 1) << 20) | $urandom_range(0, 3);
    endfunction

    initial begin
        bit [31:0] pc, lpc, tgt, ptgt;
        bit h, t, upt;
        reset = 1; lookup_pc = 0; update_valid = 0; update_pc = 0; update_taken = 0;
        update_target = 0; update_pred_taken = 0; update_pred_target = 0; flush = 0;
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 0; m_tag[i] = 0; m_target[i] = 0; m_ctr[i] = 0;
        end
        m_mis = 0; m_bc = 0; m_mc = 0;
        @(negedge clock);

        // Reset state
        step(1, 32'h0040_0010, 0, 0, 0, 0, 0, 0, 0);
        look(32'h0040_0010);
        chk("reset_next_pc", predict_next_pc, 32'h0040_0014);

        // Allocate, then pulse drops after one cycle
        upd(32'h40, 1, 32'h100, 0, 32'h0);
        chk("alloc_mispredict", 32'(mispredict), 32'h1);
        look(32'h40);
        chk("alloc_next_pc", predict_next_pc, 32'h100);
        chk("pulse_one_cycle", 32'(mispredict), 32'h0);

        // Saturate up, then walk down past zero
        repeat (3) upd(32'h40, 1, 32'h100, 1, 32'h100);
        repeat (2) upd(32'h40, 0, 32'h0, 1, 32'h100);
        look(32'h40);
        chk("weak_nt_next_pc", predict_next_pc, 32'h44);
        repeat (2) upd(32'h40, 0, 32'h0, 0, 32'h0);
        upd(32'h40, 1, 32'h100, 0, 32'h0);
        look(32'h40);
        chk("from_zero_taken", 32'(predict_taken), 32'h0);

        // Aliasing
        look(32'h440);
        upd(32'h440, 1, 32'h200, 0, 32'h0);
        look(32'h440);
        chk("alias_next_pc", predict_next_pc, 32'h200);
        look(32'h40);
        upd(32'h80, 0, 32'h0, 0, 32'h0);
        look(32'h80);

        // Flush priority, then same-cycle lookup sees old contents
        step(0, 32'h440, 1, 32'h40, 1, 32'h300, 0, 32'h0, 1);
        look(32'h440);
        look(32'h40);
        upd(32'h40, 1, 32'h180, 0, 32'h0);
        look(32'h40);
        chk("post_update_next_pc", predict_next_pc, 32'h180);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            pc  = rand_pc();
            lpc = ($urandom_range(0, 1) != 0) ? pc : rand_pc();
            case ($urandom_range(0, 3))
                0: tgt = 32'h100;
                1: tgt = 32'h200;
                2: tgt = 32'h300;
                default: tgt = $urandom();
            endcase
            if ($urandom_range(0, 1) != 0) begin
                m_lookup(pc, h, t, ptgt);
                upt = t;
            end else begin
                upt = 1'($urandom_range(0, 1));
                ptgt = ($urandom_range(0, 1) != 0) ? tgt : $urandom();
            end
            step($urandom_range(0, 149) == 0, lpc, $urandom_range(0, 3) != 0, pc,
                 1'($urandom_range(0, 1)), tgt, upt, ptgt, $urandom_range(0, 39) == 0);
        end

        // Mid-sequence reset with nonzero counters
        upd(32'h40, 1, 32'h500, 0, 32'h0);
        step(1, 32'h40, 1, 32'h40, 1, 32'h600, 0, 32'h0, 0);
        chk("rst_branch_count", branch_count, 32'h0);
        look(32'h40);

        // Statistics saturation: preload near the top, then two mispredicting updates
        force dut.branch_count = 32'hFFFF_FFFE;
        force dut.mispredict_count = 32'hFFFF_FFFE;
        m_bc = 64'hFFFF_FFFE; m_mc = 64'hFFFF_FFFE;
        look(32'h0);
        release dut.branch_count;
        release dut.mispredict_count;
        upd(32'h84, 1, 32'h700, 0, 32'h0);
        upd(32'h84, 0, 32'h0, 1, 32'h700);
        chk("sat_branch_count", branch_count, 32'hFFFF_FFFF);
        chk("sat_mispredict_count", mispredict_count, 32'hFFFF_FFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
